// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix register file: default element width and
// matrix dimension, the controller state type, and a row-major index helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int ELEM_W_DEF = 16;
  localparam int DIM_DEF    = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Row-major element number of (r,c) in a dim x dim matrix.
  function automatic int mat_idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

endpackage

// File: rtl/mat_transpose.sv
// -----------------------------------------------------------------------------
// mat_transpose
// Purely combinational matrix transpose: output element (r,c) is input
// element (c,r). Only compiled when MATRIX_REGFILE_TRANSPOSE_EN is defined,
// so the default build carries no transpose logic at all.
// Ports:
//   i_mat  in   DIM*DIM*ELEM_W  row-major source matrix
//   o_mat  out  DIM*DIM*ELEM_W  row-major transposed matrix
// -----------------------------------------------------------------------------
`ifdef MATRIX_REGFILE_TRANSPOSE_EN
module mat_transpose
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic [DIM*DIM*ELEM_W-1:0] i_mat,
  output logic [DIM*DIM*ELEM_W-1:0] o_mat
);

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign o_mat[mat_idx(r, c, DIM)*ELEM_W +: ELEM_W] =
             i_mat[mat_idx(c, r, DIM)*ELEM_W +: ELEM_W];
    end
  end

endmodule
`endif

// File: rtl/matrix_regfile.sv
// -----------------------------------------------------------------------------
// matrix_regfile
// DEPTH-entry register file whose entries are DIM x DIM signed matrices
// (row-major). Supports masked per-element writes, registered reads with a
// one-cycle response, an error response for out-of-range addresses, and a
// bulk clear that zeroes one entry per cycle.
// Optional feature: MATRIX_REGFILE_TRANSPOSE_EN enables transposed reads via
// req_trans; without it req_trans is ignored.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready depends only on the controller state (1 in IDLE, 0 in CLEAR), so
// one request per cycle is sustainable in IDLE. Reads answer with a single
// cycle rsp_valid pulse the cycle after acceptance; writes give no response.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready
//   req_write  in   1 = write, 0 = read
//   req_addr   in   AW       entry index
//   req_wdata  in   MW       write matrix
//   req_wmask  in   DIM*DIM  per-element write enable
//   req_trans  in   transposed read (only with MATRIX_REGFILE_TRANSPOSE_EN)
//   rsp_valid  out  one-cycle read-data-valid pulse
//   rsp_data   out  MW       read matrix, zero when rsp_valid=0
//   rsp_err    out  read address was >= DEPTH
//   clr_start  in   start bulk clear (IDLE only)
//   busy       out  bulk clear in progress
//   dbg_state  out  controller state for observation
// -----------------------------------------------------------------------------
module matrix_regfile
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF,
  parameter int DEPTH  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NE    = DIM * DIM,
  localparam int MW    = NE * ELEM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [MW-1:0] req_wdata,
  input  logic [NE-1:0] req_wmask,
  input  logic          req_trans,
  output logic          rsp_valid,
  output logic [MW-1:0] rsp_data,
  output logic          rsp_err,
  input  logic          clr_start,
  output logic          busy,
  output state_t        dbg_state
);

  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [MW-1:0] r_rsp_data;

  logic          w_accept;
  logic          w_addr_ok;
  logic          w_wr;
  logic          w_rd;
  logic          w_clearing;
  logic [MW-1:0] w_ent [DEPTH];
  logic [MW-1:0] w_rd_row;
  logic [MW-1:0] w_rd_sel;

  assign w_clearing = (r_state == CLEAR);
  assign req_ready  = (r_state == IDLE);
  assign busy       = w_clearing;
  assign dbg_state  = r_state;

  assign w_accept  = req_valid && req_ready;
  // Non-power-of-two DEPTH leaves addresses that decode to no entry.
  assign w_addr_ok = (32'(req_addr) < DEPTH);
  assign w_wr      = w_accept && req_write && w_addr_ok;
  assign w_rd      = w_accept && !req_write;

  // Controller. A clr_start in IDLE coexists with an accepted request: the
  // request completes on this edge and clearing begins on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (r_clr_ptr == AW'(DEPTH - 1)) begin
            r_state <= IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage: one flop row per entry so reset can zero everything at once.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [MW-1:0] r_ent;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ent <= '0;
      end else if (w_clearing && (r_clr_ptr == AW'(e))) begin
        r_ent <= '0;
      end else if (w_wr && (req_addr == AW'(e))) begin
        for (int i = 0; i < NE; i++) begin
          if (req_wmask[i]) begin
            r_ent[i*ELEM_W +: ELEM_W] <= req_wdata[i*ELEM_W +: ELEM_W];
          end
        end
      end
    end

    assign w_ent[e] = r_ent;
  end

  always_comb begin
    w_rd_row = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (req_addr == AW'(e)) begin
        w_rd_row = w_ent[e];
      end
    end
  end

`ifdef MATRIX_REGFILE_TRANSPOSE_EN
  logic [MW-1:0] w_rd_trans;

  mat_transpose #(
    .ELEM_W (ELEM_W),
    .DIM    (DIM)
  ) u_transpose (
    .i_mat (w_rd_row),
    .o_mat (w_rd_trans)
  );

  assign w_rd_sel = req_trans ? w_rd_trans : w_rd_row;
`else
  logic w_unused_trans;
  assign w_unused_trans = req_trans;
  assign w_rd_sel       = w_rd_row;
`endif

  // Read response: data is captured from the pre-edge contents, and forced to
  // zero whenever there is no valid, in-range read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      r_rsp_err   <= w_rd && !w_addr_ok;
      r_rsp_data  <= (w_rd && w_addr_ok) ? w_rd_sel : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_matrix_regfile.sv
// -----------------------------------------------------------------------------
// tb_matrix_regfile
// Directed bench for matrix_regfile: one DEPTH=4 instance for the main
// function and one DEPTH=3 instance for out-of-range addressing.
// -----------------------------------------------------------------------------
module tb_matrix_regfile;

  localparam int EW  = 16;
  localparam int DIM = 4;
  localparam int NE  = 16;
  localparam int MW  = 256;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DEPTH=4 instance ----------------
  logic          req_valid, req_write, req_trans, clr_start;
  logic [1:0]    req_addr;
  logic [MW-1:0] req_wdata;
  logic [NE-1:0] req_wmask;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [MW-1:0] rsp_data;
  matrix_pkg::state_t dbg_state;

  matrix_regfile #(.ELEM_W(EW), .DIM(DIM), .DEPTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .req_trans (req_trans),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .clr_start (clr_start),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- DEPTH=3 instance ----------------
  logic          d3_req_valid, d3_req_write, d3_req_trans, d3_clr_start;
  logic [1:0]    d3_req_addr;
  logic [MW-1:0] d3_req_wdata;
  logic [NE-1:0] d3_req_wmask;
  logic          d3_req_ready, d3_rsp_valid, d3_rsp_err, d3_busy;
  logic [MW-1:0] d3_rsp_data;
  matrix_pkg::state_t d3_dbg_state;

  matrix_regfile #(.ELEM_W(EW), .DIM(DIM), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (d3_req_valid),
    .req_ready (d3_req_ready),
    .req_write (d3_req_write),
    .req_addr  (d3_req_addr),
    .req_wdata (d3_req_wdata),
    .req_wmask (d3_req_wmask),
    .req_trans (d3_req_trans),
    .rsp_valid (d3_rsp_valid),
    .rsp_data  (d3_rsp_data),
    .rsp_err   (d3_rsp_err),
    .clr_start (d3_clr_start),
    .busy      (d3_busy),
    .dbg_state (d3_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] mdl [4];   // expected contents of the DEPTH=4 instance

  // ---------------- pattern builders ----------------
  function automatic logic [MW-1:0] fill(input logic [EW-1:0] v);
    logic [MW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*EW +: EW] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] seq_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*EW +: EW] = EW'(i + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] tag_mat(input int e);
    logic [MW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*EW +: EW] = EW'(e * 256 + i);
    return m;
  endfunction

  // ---------------- driver tasks (called at a negedge, return at the next) --
  task automatic wr4(input logic [1:0] a, input logic [MW-1:0] d, input logic [NE-1:0] m);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd4(input logic [1:0] a, input logic t,
                     output logic [MW-1:0] d, output logic v, output logic e);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_trans = t;
    @(negedge clk);
    req_valid = 1'b0; req_trans = 1'b0;
    d = rsp_data; v = rsp_valid; e = rsp_err;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [MW-1:0] d, input logic [NE-1:0] m);
    d3_req_valid = 1'b1; d3_req_write = 1'b1; d3_req_addr = a; d3_req_wdata = d; d3_req_wmask = m;
    @(negedge clk);
    d3_req_valid = 1'b0; d3_req_write = 1'b0;
  endtask

  task automatic rd3(input logic [1:0] a,
                     output logic [MW-1:0] d, output logic v, output logic e);
    d3_req_valid = 1'b1; d3_req_write = 1'b0; d3_req_addr = a;
    @(negedge clk);
    d3_req_valid = 1'b0;
    d = d3_rsp_data; v = d3_rsp_valid; e = d3_rsp_err;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (rsp_data !== '0) begin n_errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (d3_req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_d3: got %b want 1", d3_req_ready); end
  endtask

  task automatic test_full_write();
    logic [MW-1:0] d; logic v, e;
    wr4(2'd2, seq_mat(), 16'hFFFF);
    rd4(2'd2, 1'b0, d, v, e);
    n_checks++; if (v !== 1'b1) begin n_errors++; $display("FAIL full_rsp_valid: got %b want 1", v); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL full_rsp_err: got %b want 0", e); end
    n_checks++; if (d !== seq_mat()) begin n_errors++; $display("FAIL full_data: got %h want %h", d, seq_mat()); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL full_pulse_end: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_errors++; $display("FAIL full_data_idle: got %h want 0", rsp_data); end
  endtask

  task automatic test_mask();
    logic [MW-1:0] d, exp; logic v, e;
    exp = seq_mat();
    exp[0 +: EW]  = 16'hAAAA;
    exp[EW +: EW] = 16'hAAAA;
    wr4(2'd2, fill(16'hAAAA), 16'h0003);
    rd4(2'd2, 1'b0, d, v, e);
    n_checks++; if (v !== 1'b1) begin n_errors++; $display("FAIL mask_rsp_valid: got %b want 1", v); end
    n_checks++; if (d !== exp) begin n_errors++; $display("FAIL mask_data: got %h want %h", d, exp); end
    mdl[2] = exp;
  endtask

  task automatic test_back_to_back();
    logic [1:0] order [4];
    logic [MW-1:0] want;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd2;
    wr4(2'd0, tag_mat(0), 16'hFFFF);
    wr4(2'd1, tag_mat(1), 16'hFFFF);
    wr4(2'd3, tag_mat(3), 16'hFFFF);
    mdl[0] = tag_mat(0); mdl[1] = tag_mat(1); mdl[3] = tag_mat(3);
    // Partial write to entry 1 immediately followed by the read stream.
    wr4(2'd1, fill(16'h7E57), 16'h00F0);
    for (int i = 4; i < 8; i++) mdl[1][i*EW +: EW] = 16'h7E57;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = order[k];
      exp_q.push_back(mdl[order[k]]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, rsp_valid); end
      n_checks++; if (rsp_data !== want) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rsp_data, want); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_clear();
    int cnt;
    logic [MW-1:0] d; logic v, e;
    cnt = 0;
    // Read of entry 2 in the same cycle as clr_start must still complete.
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;   // clr_start stays high one more cycle, inside CLEAR
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== mdl[2]) begin
      n_errors++; $display("FAIL clr_same_cycle_read: got v=%b %h want v=1 %h", rsp_valid, rsp_data, mdl[2]);
    end
    for (int k = 0; k < 10; k++) begin
      if (busy === 1'b1 && req_ready === 1'b0) cnt++;
      @(negedge clk);
      clr_start = 1'b0;
    end
    n_checks++; if (cnt !== 4) begin n_errors++; $display("FAIL clr_busy_cycles: got %0d want 4", cnt); end
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++; $display("FAIL clr_done: got busy=%b ready=%b want busy=0 ready=1", busy, req_ready);
    end
    for (int a = 0; a < 4; a++) begin
      rd4(2'(a), 1'b0, d, v, e);
      n_checks++; if (v !== 1'b1 || d !== '0) begin
        n_errors++; $display("FAIL clr_entry[%0d]: got v=%b %h want v=1 0", a, v, d);
      end
      mdl[a] = '0;
    end
  endtask

  task automatic test_depth3();
    logic [MW-1:0] d, want [3]; logic v, e;
    want[0] = fill(16'h1111); want[1] = fill(16'h2222); want[2] = fill(16'h3333);
    for (int a = 0; a < 3; a++) wr3(2'(a), want[a], 16'hFFFF);
    wr3(2'd3, fill(16'hFFFF), 16'hFFFF);
    rd3(2'd3, d, v, e);
    n_checks++; if (v !== 1'b1) begin n_errors++; $display("FAIL d3_oob_valid: got %b want 1", v); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL d3_oob_err: got %b want 1", e); end
    n_checks++; if (d !== '0) begin n_errors++; $display("FAIL d3_oob_data: got %h want 0", d); end
    for (int a = 0; a < 3; a++) begin
      rd3(2'(a), d, v, e);
      n_checks++; if (v !== 1'b1 || e !== 1'b0 || d !== want[a]) begin
        n_errors++; $display("FAIL d3_entry[%0d]: got v=%b e=%b %h want v=1 e=0 %h", a, v, e, d, want[a]);
      end
    end
  endtask

  task automatic test_transpose();
    logic [MW-1:0] m, mt, d, want; logic v, e;
    m = '0;
    for (int r = 0; r < DIM; r++) m[(r*DIM + r)*EW +: EW] = 16'h0001;
    mt = m;
    m[(0*DIM + 1)*EW +: EW]  = 16'h0005;   // element (0,1)
    mt[(1*DIM + 0)*EW +: EW] = 16'h0005;   // element (1,0)
    wr4(2'd0, m, 16'hFFFF);
`ifdef MATRIX_REGFILE_TRANSPOSE_EN
    want = mt;
`else
    want = m;
`endif
    rd4(2'd0, 1'b1, d, v, e);
    n_checks++; if (d[(0*DIM + 1)*EW +: EW] !== want[(0*DIM + 1)*EW +: EW]) begin
      n_errors++; $display("FAIL trans_e01: got %h want %h", d[(0*DIM + 1)*EW +: EW], want[(0*DIM + 1)*EW +: EW]);
    end
    n_checks++; if (d[(1*DIM + 0)*EW +: EW] !== want[(1*DIM + 0)*EW +: EW]) begin
      n_errors++; $display("FAIL trans_e10: got %h want %h", d[(1*DIM + 0)*EW +: EW], want[(1*DIM + 0)*EW +: EW]);
    end
    n_checks++; if (v !== 1'b1 || d !== want) begin
      n_errors++; $display("FAIL trans_full: got v=%b %h want v=1 %h", v, d, want);
    end
    rd4(2'd0, 1'b0, d, v, e);
    n_checks++; if (d !== m) begin n_errors++; $display("FAIL trans_off: got %h want %h", d, m); end
  endtask

  task automatic test_reset_abort();
    logic [MW-1:0] d; logic v, e;
    int seen;
    for (int a = 0; a < 4; a++) wr4(2'(a), fill(16'h0C00 + 16'(a)), 16'hFFFF);
    // Clear aborted two cycles in: entries 2,3 were never reached by the
    // pointer, so only reset can zero them.
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_clr_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++; $display("FAIL abort_clr_busy: got busy=%b ready=%b want busy=0 ready=1", busy, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr4(2'd3, fill(16'h5A5A), 16'hFFFF);
    // Read accepted, then reset lands in the cycle its response is visible.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      n_errors++; $display("FAIL abort_rd_reset: got v=%b %h want v=0 0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL abort_no_pulse: got %0d pulses want 0", seen); end
    for (int a = 0; a < 4; a++) begin
      rd4(2'(a), 1'b0, d, v, e);
      n_checks++; if (v !== 1'b1 || d !== '0) begin
        n_errors++; $display("FAIL abort_entry[%0d]: got v=%b %h want v=1 0", a, v, d);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_trans = 1'b0; clr_start = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    d3_req_valid = 1'b0; d3_req_write = 1'b0; d3_req_trans = 1'b0; d3_clr_start = 1'b0;
    d3_req_addr = '0; d3_req_wdata = '0; d3_req_wmask = '0;
    for (int a = 0; a < 4; a++) mdl[a] = '0;

    test_reset();
    test_full_write();
    test_mask();
    test_back_to_back();
    test_clear();
    test_depth3();
    test_transpose();
    test_reset_abort();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
